// File: rtl/decode_pkg.sv
// Shared decode constants for the core: class codes, condition codes,
// major-op and opcode values, fixed encodings and the condition evaluator.
//
// Decode rules, with cond = instr[31:28] and op = instr[27:26]:
//   cond=1111, op=00           -> UNCOND (no fields)
//   cond=1111, any other op    -> NONE
//   instr[27:4] = 0x12FFF1     -> BX      (rm)
//   instr[27:0] = 0x160006E    -> ERET    (no fields)
//   op=00, opcode=1101 (MOV)   -> MOV_LAS (rd, s, imm12 | rm [+ rs when instr[4]])
//   op=00, any other opcode    -> DP      (rn, rd, s, imm12 | rm [+ rs when instr[4]])
//   op=01                      -> LDST    (rn, rd, imm12 when I=0 | rm when I=1)
//   op=10                      -> B       (br_off24, link)
//   op=11                      -> NONE
package decode_pkg;

  typedef enum logic [4:0] {
    CLS_NONE    = 5'd0,
    CLS_DP      = 5'd1,
    CLS_MOV_LAS = 5'd2,
    CLS_LDST    = 5'd3,
    CLS_B       = 5'd4,
    CLS_BX      = 5'd5,
    CLS_ERET    = 5'd6,
    CLS_UNCOND  = 5'd7
  } instr_class_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_LDST = 2'b01;
  localparam logic [1:0] OP_B    = 2'b10;

  localparam logic [3:0]  OPC_MOV      = 4'b1101;
  localparam logic [23:0] BX_PATTERN   = 24'h12FFF1;
  localparam logic [27:0] ERET_PATTERN = 28'h160006E;

  typedef struct packed {
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [11:0] imm12;
    logic [23:0] br_off24;
    logic        link;
    logic        s;
  } dec_fields_t;

  // True when the condition holds for flags {n,z,c,v}; 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Storage is not reset; only pointers and level are.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == {(AW+1){1'b0}});
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & !o_full & !i_clr;
  assign w_do_pop  = i_pop & !o_empty & !i_clr;

  // Storage write; contents survive reset and clear.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; clear dominates push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else if (i_clr) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/instr_queue_decoder.sv
// Prefetch queue followed by a single decode/output stage. The head word is
// decoded combinationally and captured on pop; the condition check against
// the live flags is combinational from the captured cond field.
module instr_queue_decoder
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [3:0]  nzcv,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_class,
  output logic [31:0] out_pc,
  output logic [3:0]  out_rn,
  output logic [3:0]  out_rd,
  output logic [3:0]  out_rm,
  output logic [3:0]  out_rs,
  output logic [11:0] out_imm12,
  output logic [23:0] out_br_off24,
  output logic        out_link,
  output logic        out_s,
  output logic        out_skip,
  output logic        out_write_rd,
  output logic        out_br_en,
  output logic [AW:0] level
);

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic [63:0]  w_head;
  logic [31:0]  w_instr;
  logic [3:0]   w_cond;
  logic [1:0]   w_op;
  logic         w_is_mov;
  instr_class_e w_cls;
  dec_fields_t  w_fld;
  logic         w_skip;

  logic         r_out_valid;
  instr_class_e r_class;
  logic [3:0]   r_cond;
  logic [31:0]  r_pc;
  dec_fields_t  r_fld;

  assign in_ready = !w_full & !flush;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = !w_empty & !flush & (!r_out_valid | out_ready);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64),
    .AW    (AW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_instr, in_pc}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_instr  = w_head[63:32];
  assign w_cond   = w_instr[31:28];
  assign w_op     = w_instr[27:26];
  assign w_is_mov = (w_instr[24:21] == OPC_MOV);

  // Classify the head word and extract only the fields its class uses.
  always_comb begin
    w_cls = CLS_NONE;
    w_fld = '0;
    if (w_op == OP_DP && w_cond == COND_NV) begin
      w_cls = CLS_UNCOND;
    end else if (w_cond == COND_NV) begin
      w_cls = CLS_NONE;
    end else if (w_instr[27:4] == BX_PATTERN) begin
      w_cls    = CLS_BX;
      w_fld.rm = w_instr[3:0];
    end else if (w_instr[27:0] == ERET_PATTERN) begin
      w_cls = CLS_ERET;
    end else begin
      case (w_op)
        OP_DP: begin
          w_cls    = w_is_mov ? CLS_MOV_LAS : CLS_DP;
          w_fld.rn = w_is_mov ? 4'h0 : w_instr[19:16];
          w_fld.rd = w_instr[15:12];
          w_fld.s  = w_instr[20];
          if (w_instr[25]) begin
            w_fld.imm12 = w_instr[11:0];
          end else begin
            w_fld.rm = w_instr[3:0];
            w_fld.rs = w_instr[4] ? w_instr[11:8] : 4'h0;
          end
        end
        OP_LDST: begin
          w_cls    = CLS_LDST;
          w_fld.rn = w_instr[19:16];
          w_fld.rd = w_instr[15:12];
          if (w_instr[25]) begin
            w_fld.rm = w_instr[3:0];
          end else begin
            w_fld.imm12 = w_instr[11:0];
          end
        end
        OP_B: begin
          w_cls          = CLS_B;
          w_fld.br_off24 = w_instr[23:0];
          w_fld.link     = w_instr[24];
        end
        default: begin
          w_cls = CLS_NONE;
        end
      endcase
    end
  end

  // Output stage: flush clears valid, pop loads, consume without pop clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_class     <= CLS_NONE;
      r_cond      <= 4'h0;
      r_pc        <= 32'h0;
      r_fld       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_class     <= w_cls;
      r_cond      <= w_cond;
      r_pc        <= w_head[31:0];
      r_fld       <= w_fld;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Condition-failed flag from the staged cond and the live flags.
  always_comb begin
    w_skip = 1'b1;
    case (r_class)
      CLS_NONE:   w_skip = 1'b1;
      CLS_UNCOND: w_skip = 1'b0;
      default:    w_skip = !cond_pass(r_cond, nzcv);
    endcase
  end

  assign out_valid    = r_out_valid;
  assign out_class    = r_class;
  assign out_pc       = r_pc;
  assign out_rn       = r_fld.rn;
  assign out_rd       = r_fld.rd;
  assign out_rm       = r_fld.rm;
  assign out_rs       = r_fld.rs;
  assign out_imm12    = r_fld.imm12;
  assign out_br_off24 = r_fld.br_off24;
  assign out_link     = r_fld.link;
  assign out_s        = r_fld.s;
  assign out_skip     = w_skip;
  assign out_write_rd = !w_skip & ((r_class == CLS_DP) | (r_class == CLS_MOV_LAS) |
                                   (r_class == CLS_LDST));
  assign out_br_en    = !w_skip & ((r_class == CLS_B) | (r_class == CLS_BX) |
                                   (r_class == CLS_ERET));

endmodule

// File: tb/tb_instr_queue_decoder.sv
// Self-checking bench: a queue-based reference model is compared with the
// DUT every cycle, plus directed literal scenarios and randomized traffic.
module tb_instr_queue_decoder;
  import decode_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [3:0]  nzcv;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic [31:0] out_pc;
  logic [3:0]  out_rn, out_rd, out_rm, out_rs;
  logic [11:0] out_imm12;
  logic [23:0] out_br_off24;
  logic        out_link, out_s, out_skip, out_write_rd, out_br_en;
  logic [2:0]  level;

  instr_queue_decoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .nzcv(nzcv), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_pc(out_pc), .out_rn(out_rn), .out_rd(out_rd), .out_rm(out_rm),
    .out_rs(out_rs), .out_imm12(out_imm12), .out_br_off24(out_br_off24),
    .out_link(out_link), .out_s(out_s), .out_skip(out_skip),
    .out_write_rd(out_write_rd), .out_br_en(out_br_en), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  cls;
    logic [3:0]  cond;
    logic [31:0] pc;
    logic [3:0]  rn, rd, rm, rs;
    logic [11:0] imm;
    logic [23:0] off;
    logic        link, s;
  } dec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] q[$];
  logic        sv;
  dec_t        e;
  logic [31:0] consumed[$];
  logic [31:0] accepted[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM condition pairs: even code is the base test, odd code its inverse.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & !z;
      3'd5: base = (n == v);
      3'd6: base = !z & (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic dec_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    d = '0;
    d.cls  = CLS_NONE;
    d.cond = w[31:28];
    d.pc   = pc;
    if (w[31:28] == 4'hF) begin
      d.cls = (w[27:26] == 2'b00) ? CLS_UNCOND : CLS_NONE;
    end else if (w[27:4] == 24'h12FFF1) begin
      d.cls = CLS_BX; d.rm = w[3:0];
    end else if (w[27:0] == 28'h160006E) begin
      d.cls = CLS_ERET;
    end else if (w[27:26] == 2'b00) begin
      d.cls = (w[24:21] == 4'hD) ? CLS_MOV_LAS : CLS_DP;
      d.rn  = (w[24:21] == 4'hD) ? 4'h0 : w[19:16];
      d.rd  = w[15:12];
      d.s   = w[20];
      if (w[25]) d.imm = w[11:0];
      else begin
        d.rm = w[3:0];
        if (w[4]) d.rs = w[11:8];
      end
    end else if (w[27:26] == 2'b01) begin
      d.cls = CLS_LDST; d.rn = w[19:16]; d.rd = w[15:12];
      if (w[25]) d.rm = w[3:0];
      else d.imm = w[11:0];
    end else if (w[27:26] == 2'b10) begin
      d.cls = CLS_B; d.off = w[23:0]; d.link = w[24];
    end
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    sv = 1'b0;
    e = '0;
    e.cls = CLS_NONE;
  endtask

  task automatic model_step();
    logic [63:0] item;
    logic        do_push, do_pop;
    if (flush) begin
      q.delete();
      sv = 1'b0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && (!sv || out_ready);
      if (do_pop) begin
        item = q.pop_front();
        e = model_decode(item[63:32], item[31:0]);
        sv = 1'b1;
      end else if (out_ready) begin
        sv = 1'b0;
      end
      if (do_push) q.push_back({in_instr, in_pc});
    end
  endtask

  task automatic compare_all();
    logic xs, xw, xb;
    if (e.cls == CLS_NONE) xs = 1'b1;
    else if (e.cls == CLS_UNCOND) xs = 1'b0;
    else xs = !cond_ok(e.cond, nzcv);
    xw = !xs && (e.cls == CLS_DP || e.cls == CLS_MOV_LAS || e.cls == CLS_LDST);
    xb = !xs && (e.cls == CLS_B || e.cls == CLS_BX || e.cls == CLS_ERET);
    check("level", 64'(level), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && !flush));
    check("out_valid", 64'(out_valid), 64'(sv));
    check("class", 64'(out_class), 64'(e.cls));
    check("pc", 64'(out_pc), 64'(e.pc));
    check("rn", 64'(out_rn), 64'(e.rn));
    check("rd", 64'(out_rd), 64'(e.rd));
    check("rm", 64'(out_rm), 64'(e.rm));
    check("rs", 64'(out_rs), 64'(e.rs));
    check("imm12", 64'(out_imm12), 64'(e.imm));
    check("br_off24", 64'(out_br_off24), 64'(e.off));
    check("link", 64'(out_link), 64'(e.link));
    check("s", 64'(out_s), 64'(e.s));
    check("skip", 64'(out_skip), 64'(xs));
    check("write_rd", 64'(out_write_rd), 64'(xw));
    check("br_en", 64'(out_br_en), 64'(xb));
  endtask

  // Called at a falling edge: drive, compare, advance model, wait one cycle.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic ordy, input logic [3:0] f);
    in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy; nzcv = f;
    #1;
    compare_all();
    if (out_valid && out_ready && !flush) consumed.push_back(out_pc);
    if (in_valid && in_ready) accepted.push_back(in_pc);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [3:0] c;
    c = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return {c, 24'h12FFF1, 4'($urandom_range(0, 15))};
      2: return {c, 28'h160006E};
      3: return {c, 2'b00, 1'($urandom_range(0, 1)), 4'hD, 21'($urandom)};
      4: return {c, 3'b101, 1'($urandom_range(0, 1)), 24'($urandom)};
      default: return {c, 2'b01, 26'($urandom)};
    endcase
  endfunction

  task automatic set_flags_check(input logic [3:0] f, input logic xs, input logic xb, input string tag);
    nzcv = f;
    #1;
    check({tag, "_skip"}, 64'(out_skip), 64'(xs));
    check({tag, "_br_en"}, 64'(out_br_en), 64'(xb));
  endtask

  task automatic mid_reset();
    #2;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_class", 64'(out_class), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'hE1A03004, 32'h0000_3000, 1'b0, 1'b0, 4'h0);
    check("rst_first_push", 64'(level), 64'd1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    nzcv = 4'h0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    compare_all();
    check("reset_skip", 64'(out_skip), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // MOV r1, r2 through an empty queue
    step(1'b1, 32'hE1A01002, 32'h0000_0100, 1'b0, 1'b1, 4'h0);
    check("first_push_level", 64'(level), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0);
    check("mov_valid", 64'(out_valid), 64'd1);
    check("mov_class", 64'(out_class), 64'(CLS_MOV_LAS));
    check("mov_rd", 64'(out_rd), 64'd1);
    check("mov_rm", 64'(out_rm), 64'd2);
    check("mov_pc", 64'(out_pc), 64'h100);
    check("mov_skip", 64'(out_skip), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0);

    // BGT held in the stage while the flags change
    step(1'b1, 32'hCA000010, 32'h0000_0200, 1'b0, 1'b0, 4'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    check("bgt_class", 64'(out_class), 64'(CLS_B));
    check("bgt_off", 64'(out_br_off24), 64'h10);
    set_flags_check(4'b0000, 1'b0, 1'b1, "bgt_0000");
    set_flags_check(4'b0100, 1'b1, 1'b0, "bgt_0100");
    set_flags_check(4'b1000, 1'b1, 1'b0, "bgt_1000");
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0);

    // Back-pressure: 6 offered, 5 accepted, then ordered drain
    consumed.delete(); accepted.delete();
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'hE3A00000 | 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 4'h0);
    check("bp_accepts", 64'(accepted.size()), 64'd5);
    check("bp_level", 64'(level), 64'd4);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0);
    check("bp_drained", 64'(consumed.size()), 64'd5);
    for (int i = 0; i < 5 && i < consumed.size(); i++)
      check("bp_order", 64'(consumed[i]), 64'(32'h1000 + 32'(4 * i)));

    // Flush with three queued entries and a push offered
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'hE0812003, 32'h2000 + 32'(4 * i), 1'b0, 1'b0, 4'h0);
    check("fl_pre_level", 64'(level), 64'd3);
    step(1'b1, 32'hE0812003, 32'h0000_2FFF, 1'b1, 1'b0, 4'h0);
    check("fl_level", 64'(level), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0);
    check("fl_discard", 64'(out_valid), 64'd0);

    // Fill, then sustained push+pop across pointer wrap
    consumed.delete(); accepted.delete();
    for (int i = 0; i < 5; i++)
      step(1'b1, gen_instr(), 32'h4000 + 32'(4 * i), 1'b0, 1'b0, 4'h0);
    check("wrap_full", 64'(level), 64'd4);
    for (int i = 5; i < 20; i++)
      step(1'b1, gen_instr(), 32'h4000 + 32'(4 * i), 1'b0, 1'b1, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0);
    check("wrap_count", 64'(consumed.size()), 64'(accepted.size()));
    for (int i = 0; i < consumed.size() && i < accepted.size(); i++)
      check("wrap_order", 64'(consumed[i]), 64'(accepted[i]));

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step(1'($urandom_range(0, 9) < 7), gen_instr(), $urandom,
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 9) < 6),
           4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
